// File: rtl/adma_data_fifo.sv
// adma_data_fifo: single-clock circular-buffer FIFO between the ADMA engine
// and the SD data line. Occupancy is tracked by a registered word count, and
// all status flags are decoded from that count only, so no request input has
// a combinational path to any flag. Read data is registered, so a word
// appears on data_out one cycle after its read request is accepted.
//
// Handshake: a write is taken on a rising CLK edge when fifo_write is high and
// the FIFO is not full, or is full but a read is accepted on the same edge. A
// read is taken when fifo_read is high and the FIFO is not empty. A request
// that cannot be taken is dropped, and the matching sticky error flag is set.
// flush overrides both requests on the same edge.
module adma_data_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  fifo_write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  flush,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_COUNT   = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_COUNT   = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;

    logic wr_accept;
    logic rd_accept;
    logic wr_drop;
    logic rd_drop;

    // Flags are pure decodes of the registered count.
    assign fifo_full    = (count == FULL_COUNT);
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= AF_COUNT);
    assign almost_empty = (count <= AE_COUNT);

    // Request qualification. When full, a concurrent read frees the slot the
    // write fills. When empty, a concurrent write is not bypassed to the read.
    assign wr_accept = ~flush & fifo_write & (~fifo_full | fifo_read);
    assign rd_accept = ~flush & fifo_read & ~fifo_empty;
    assign wr_drop   = ~flush & fifo_write & fifo_full & ~fifo_read;
    assign rd_drop   = ~flush & fifo_read & fifo_empty;

    // Storage array: written on accepted writes, never reset or cleared.
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wptr] <= data_in;
        end
    end

    // Write and read pointers wrap naturally modulo the depth.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_accept) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Occupancy count: moves only when exactly one side is accepted.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Registered read data; holds through flush and ignored reads.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            data_out <= '0;
        end else if (rd_accept) begin
            data_out <= mem[rptr];
        end
    end

    // Sticky error flags, cleared only by flush or reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (rd_drop) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adma_data_fifo.sv
// tb_adma_data_fifo: scoreboard bench for adma_data_fifo. Written words are
// pushed to an expected queue when the write is driven and popped when the
// matching read data is due on data_out; occupancy and flags come from a
// small independent model of the count and the sticky errors.
module tb_adma_data_fifo;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk;
  logic          rst_n;
  logic          fifo_write;
  logic [DW-1:0] data_in;
  logic          fifo_read;
  logic [DW-1:0] data_out;
  logic          flush;
  logic          fifo_full;
  logic          fifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [DW-1:0] exp_q[$];
  int            m_count;
  logic          m_ov;
  logic          m_uf;
  logic [DW-1:0] m_dout;

  adma_data_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .CLK(clk),
    .RESET(rst_n),
    .fifo_write(fifo_write),
    .data_in(data_in),
    .fifo_read(fifo_read),
    .data_out(data_out),
    .flush(flush),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_ov = 1'b0;
    m_uf = 1'b0;
    m_dout = '0;
  endtask

  task automatic check_state(input string where);
    check_eq({where, ":count"}, 32'(count), 32'(m_count));
    check_eq({where, ":full"}, 32'(fifo_full), 32'(m_count == DEPTH));
    check_eq({where, ":empty"}, 32'(fifo_empty), 32'(m_count == 0));
    check_eq({where, ":almost_full"}, 32'(almost_full), 32'(m_count >= AF));
    check_eq({where, ":almost_empty"}, 32'(almost_empty), 32'(m_count <= AE));
    check_eq({where, ":overflow"}, 32'(overflow), 32'(m_ov));
    check_eq({where, ":underflow"}, 32'(underflow), 32'(m_uf));
    check_eq({where, ":data_out"}, data_out, m_dout);
  endtask

  // driver: one clock of requests, model update, then checks #1 after the edge
  task automatic step(input string where, input logic wr, input logic rd, input logic fl, input logic [DW-1:0] d);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    fifo_write = wr;
    fifo_read = rd;
    flush = fl;
    data_in = d;
    if (fl) begin
      exp_q.delete();
      m_count = 0;
      m_ov = 1'b0;
      m_uf = 1'b0;
    end else begin
      rd_ok = rd && (m_count > 0);
      wr_ok = wr && ((m_count < DEPTH) || rd);
      if (wr && (m_count == DEPTH) && !rd) m_ov = 1'b1;
      if (rd && (m_count == 0)) m_uf = 1'b1;
      if (rd_ok) m_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
      if (wr_ok && !rd_ok) m_count++;
      if (rd_ok && !wr_ok) m_count--;
    end
    @(posedge clk);
    #1;
    fifo_write = 1'b0;
    fifo_read = 1'b0;
    flush = 1'b0;
    check_state(where);
  endtask

  task automatic fill_seq(input int n);
    for (int i = 0; i < n; i++) begin
      step("fill", 1'b1, 1'b0, 1'b0, 32'((i + 1) * 32'h11));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      step("drain", 1'b0, 1'b1, 1'b0, '0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fifo_write = 1'b0;
    fifo_read = 1'b0;
    flush = 1'b0;
    data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // fill 0x11..0x88, then drain in order
    fill_seq(8);
    drain(8);

    // overflow on a full FIFO; next read still returns the oldest word
    fill_seq(8);
    step("overflow", 1'b1, 1'b0, 1'b0, 32'h99);
    step("after_ovf_read", 1'b0, 1'b1, 1'b0, '0);
    step("flush1", 1'b0, 1'b0, 1'b1, '0);

    // full with simultaneous read and write; 0xAA is the last word out
    fill_seq(8);
    step("full_rw", 1'b1, 1'b1, 1'b0, 32'hAA);
    drain(8);

    // empty with simultaneous read and write: no bypass, underflow set
    step("empty_rw", 1'b1, 1'b1, 1'b0, 32'h55);
    step("read_55", 1'b0, 1'b1, 1'b0, '0);

    // flush wins over read and write at count 5
    fill_seq(5);
    step("flush_prio", 1'b1, 1'b1, 1'b1, 32'hEE);
    step("post_flush_wr", 1'b1, 1'b0, 1'b0, 32'h01);
    step("post_flush_rd", 1'b0, 1'b1, 1'b0, '0);

    // asynchronous reset between edges at count 4
    fill_seq(4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("async_reset");
    #1;
    rst_n = 1'b1;
    step("wr_77", 1'b1, 1'b0, 1'b0, 32'h77);
    step("rd_77", 1'b0, 1'b1, 1'b0, '0);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0), $urandom);
    end
    drain(DEPTH + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adma_data_fifo.md
ADMA_DATA_FIFO -- requirements
Module: adma_data_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one data word.
REQ-002 Parameter ADDR_WIDTH, default 3, log2 of depth; depth = 2^ADDR_WIDTH = 8 words.
REQ-003 Parameter AF_LEVEL, default 6, count at or above which almost_full is asserted.
REQ-004 Parameter AE_LEVEL, default 2, count at or below which almost_empty is asserted.
REQ-005 The clock port SHALL be CLK, input, 1 bit; the block uses this one clock only, and all state updates on its rising edge.
REQ-006 The reset port SHALL be RESET, input, 1 bit: asynchronous, active-low.
REQ-007 fifo_write  input  1  write request from the ADMA engine.
REQ-008 data_in  input  DATA_WIDTH  write data; this is the engine's data_to_fifo.
REQ-009 fifo_read  input  1  read request from the ADMA engine or the SD data line.
REQ-010 data_out  output  DATA_WIDTH  registered read data; this is the engine's data_from_fifo.
REQ-011 flush  input  1  synchronous clear of the contents, the pointers and the sticky flags.
REQ-012 fifo_full and fifo_empty  output  1 each  occupancy flags fed back to the engine.
REQ-013 almost_full and almost_empty  output  1 each  threshold flags.
REQ-014 count  output  ADDR_WIDTH+1  current number of stored words, 0..2^ADDR_WIDTH.
REQ-015 overflow and underflow  output  1 each  sticky error flags.

Function
REQ-016 Storage SHALL be a circular buffer with a write pointer and a read pointer, each ADDR_WIDTH bits wide, that wrap modulo the depth.
- Occupancy is tracked by count, not by pointer comparison.
REQ-017 Write accepted = fifo_write & (~fifo_full | fifo_read).
- On acceptance: mem[wptr] <= data_in; wptr increments.
REQ-018 Read accepted = fifo_read & ~fifo_empty.
- On acceptance: data_out <= mem[rptr] on the same edge, giving 1-cycle read latency; rptr increments.
- Otherwise data_out holds its value.
REQ-019 Write while full with no read: the write is dropped, overflow is set to 1, and the contents are unchanged.
REQ-020 Read while empty: the read is ignored, underflow is set to 1, and data_out holds.
- Also applies when fifo_write is asserted in the same cycle: no write-to-read bypass exists.
REQ-021 Simultaneous accepted read and write: count is unchanged and both pointers advance.
- When full, the read slot frees and the write fills it in the same edge.
REQ-022 count update: count increments on an accepted write only, decrements on an accepted read only, and is unchanged otherwise.
REQ-023 fifo_full = (count == 2^ADDR_WIDTH); fifo_empty = (count == 0).
- Both are decoded from the registered count, with no combinational path from the request inputs.
REQ-024 almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL).
REQ-025 flush SHALL take priority over fifo_read and fifo_write in the same cycle.
- Next edge: pointers = 0, count = 0, overflow = 0, underflow = 0.
- data_out holds; memory contents are not cleared.
REQ-026 overflow and underflow stay set until flush or reset.

Reset
REQ-027 While RESET = 0, and asynchronously on its assertion:
- pointers = 0, count = 0, data_out = 0;
- fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0;
- overflow = 0, underflow = 0.
REQ-028 Reset asserted mid-transfer SHALL discard all stored words; the first accepted write after release lands at address 0.
REQ-029 Memory array contents need no reset value.

Verification
REQ-030 Reset, then write 0x11..0x88 (8 words) -> count 8, fifo_full = 1, almost_full asserted from count 6; 8 reads return 0x11..0x88 in order, each one cycle after its request; fifo_empty = 1 at the end.
REQ-031 Full, fifo_write with data 0x99 and no read -> overflow = 1, count stays 8, and the next read returns 0x11.
REQ-032 Full, simultaneous read and write of 0xAA -> data_out = 0x11, count stays 8; after draining, 0xAA is the last word out; pointers have wrapped.
REQ-033 Empty, simultaneous read and write of 0x55 -> underflow = 1, data_out unchanged, count = 1; the next read returns 0x55.
REQ-034 Count 5 with flush, fifo_write and fifo_read all asserted -> count = 0, fifo_empty = 1, overflow = 0, underflow = 0; the write is discarded.
REQ-035 Count 4 and RESET pulsed low between clock edges -> outputs take reset values immediately; after release, write 0x77 then read -> 0x77.
